// File: rtl/branch_trap_sequencer_pkg.sv
// Shared opcode, trap-type and state definitions for the PC/nPC sequencer.
// Also holds the small helpers used by the sequencer and its trap detector.
package branch_trap_sequencer_pkg;

  localparam logic [1:0] OP_FMT2   = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [2:0] OP2_BICC  = 3'b010;

  localparam logic [5:0] OP3_TICC    = 6'h3A;
  localparam logic [5:0] OP3_SAVE    = 6'h3C;
  localparam logic [5:0] OP3_RESTORE = 6'h3D;

  localparam logic [3:0] COND_ALWAYS = 4'b1000;

  localparam logic [7:0] TT_WIN_OVERFLOW  = 8'h05;
  localparam logic [7:0] TT_WIN_UNDERFLOW = 8'h06;
  localparam logic [7:0] TT_TRAP_INSTR    = 8'h80;

  typedef enum logic [1:0] {
    ST_EXEC        = 2'd0,
    ST_TRAP_SAVE   = 2'd1,
    ST_TRAP_VECTOR = 2'd2,
    ST_HALT        = 2'd3
  } seq_state_e;

  // (cwp + offs) mod nwin; cwp may exceed nwin-1, the modulo folds it back.
  function automatic logic [4:0] win_wrap(input logic [4:0] cwp,
                                          input int offs,
                                          input int nwin);
    int sum;
    sum = int'(cwp) + offs;
    return 5'(sum % nwin);
  endfunction

  function automatic logic [31:0] branch_disp(input logic [21:0] disp22);
    return {{8{disp22[21]}}, disp22, 2'b00};
  endfunction

endpackage

// File: rtl/branch_trap_sequencer_trap_detect.sv
// Combinational trap detection: TA and window overflow/underflow on SAVE/RESTORE.
// An annulled instruction never traps.
module branch_trap_sequencer_trap_detect
  import branch_trap_sequencer_pkg::*;
#(
  parameter int NWIN = 4
) (
  input  logic [31:0] ir_i,
  input  logic [4:0]  cwp_i,
  input  logic [31:0] wim_i,
  input  logic        annul_i,
  output logic        trap_o,
  output logic [7:0]  tt_o
);

  logic [1:0] op;
  logic [5:0] op3;
  logic [3:0] cond;
  logic [4:0] save_idx;
  logic [4:0] restore_idx;
  logic       is_ta;
  logic       is_save;
  logic       is_restore;
  logic       unused_ir_bits;

  assign op          = ir_i[31:30];
  assign op3         = ir_i[24:19];
  assign cond        = ir_i[28:25];
  assign save_idx    = win_wrap(cwp_i, NWIN - 1, NWIN);
  assign restore_idx = win_wrap(cwp_i, 1, NWIN);

  assign is_ta      = (op == OP_ARITH) && (op3 == OP3_TICC) && (cond == COND_ALWAYS);
  assign is_save    = (op == OP_ARITH) && (op3 == OP3_SAVE);
  assign is_restore = (op == OP_ARITH) && (op3 == OP3_RESTORE);

  assign unused_ir_bits = ^{ir_i[29], ir_i[18:7]};

  always_comb begin
    trap_o = 1'b0;
    tt_o   = 8'h00;
    if (!annul_i) begin
      if (is_ta) begin
        trap_o = 1'b1;
        tt_o   = TT_TRAP_INSTR | {1'b0, ir_i[6:0]};
      end else if (is_save && wim_i[save_idx]) begin
        trap_o = 1'b1;
        tt_o   = TT_WIN_OVERFLOW;
      end else if (is_restore && wim_i[restore_idx]) begin
        trap_o = 1'b1;
        tt_o   = TT_WIN_UNDERFLOW;
      end
    end
  end

endmodule

// File: rtl/branch_trap_sequencer.sv
// PC/nPC sequencer: resolves branches, CALL, delay-slot annulment and trap entry.
// Handshake: step_i is accepted only when busy_o=0; the requester holds ir_i while busy.
module branch_trap_sequencer
  import branch_trap_sequencer_pkg::*;
#(
  parameter int          NWIN     = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        step_i,
  input  logic [31:0] ir_i,
  input  logic        cond_i,
  input  logic [4:0]  cwp_i,
  input  logic [31:0] wim_i,
  input  logic        et_i,
  input  logic [19:0] tba_i,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic        annul_o,
  output logic        busy_o,
  output logic        trap_entry_o,
  output logic [7:0]  tt_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_npc_o,
  output logic        error_mode_o,
  output logic [1:0]  state_o
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        annul_q, annul_d;
  logic [7:0]  tt_q, tt_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_npc_q, trap_npc_d;
  logic        err_q, err_d;

  logic        det_trap;
  logic [7:0]  det_tt;
  logic        is_branch;
  logic        is_call;
  logic        taken;
  logic [31:0] vector_pc;

  branch_trap_sequencer_trap_detect #(
    .NWIN (NWIN)
  ) u_trap_detect (
    .ir_i    (ir_i),
    .cwp_i   (cwp_i),
    .wim_i   (wim_i),
    .annul_i (annul_q),
    .trap_o  (det_trap),
    .tt_o    (det_tt)
  );

  assign is_branch = (ir_i[31:30] == OP_FMT2) && (ir_i[24:22] == OP2_BICC);
  assign is_call   = (ir_i[31:30] == OP_CALL);
  assign taken     = cond_i;
  assign vector_pc = {tba_i, tt_q, 4'b0000};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_EXEC;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + 32'd4;
      annul_q    <= 1'b0;
      tt_q       <= 8'h00;
      trap_pc_q  <= 32'h0;
      trap_npc_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      annul_q    <= annul_d;
      tt_q       <= tt_d;
      trap_pc_q  <= trap_pc_d;
      trap_npc_q <= trap_npc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    annul_d    = annul_q;
    tt_d       = tt_q;
    trap_pc_d  = trap_pc_q;
    trap_npc_d = trap_npc_q;
    err_d      = err_q;
    unique case (state_q)
      ST_EXEC: begin
        if (step_i) begin
          if (annul_q) begin
            pc_d    = npc_q;
            npc_d   = npc_q + 32'd4;
            annul_d = 1'b0;
          end else if (det_trap) begin
            // PC/nPC stay put so the trapping instruction's address is preserved.
            tt_d = det_tt;
            if (et_i) begin
              trap_pc_d  = pc_q;
              trap_npc_d = npc_q;
              state_d    = ST_TRAP_SAVE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end
          end else if (is_branch) begin
            pc_d    = npc_q;
            npc_d   = taken ? (pc_q + branch_disp(ir_i[21:0])) : (npc_q + 32'd4);
            annul_d = ir_i[29] & (!taken | (ir_i[28:25] == COND_ALWAYS));
          end else if (is_call) begin
            pc_d    = npc_q;
            npc_d   = pc_q + {ir_i[29:0], 2'b00};
            annul_d = 1'b0;
          end else begin
            pc_d    = npc_q;
            npc_d   = npc_q + 32'd4;
            annul_d = 1'b0;
          end
        end
      end
      ST_TRAP_SAVE: begin
        state_d = ST_TRAP_VECTOR;
      end
      ST_TRAP_VECTOR: begin
        pc_d    = vector_pc;
        npc_d   = vector_pc + 32'd4;
        annul_d = 1'b0;
        state_d = ST_EXEC;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_EXEC;
      end
    endcase
  end

  assign pc_o         = pc_q;
  assign npc_o        = npc_q;
  assign annul_o      = annul_q;
  assign busy_o       = (state_q != ST_EXEC);
  assign trap_entry_o = (state_q == ST_TRAP_VECTOR);
  assign tt_o         = tt_q;
  assign trap_pc_o    = trap_pc_q;
  assign trap_npc_o   = trap_npc_q;
  assign error_mode_o = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_branch_trap_sequencer.sv
// Directed bench for branch_trap_sequencer with hand-computed PC/nPC/trap values.
module tb_branch_trap_sequencer;

  localparam logic [31:0] NOP      = 32'h0100_0000;
  localparam logic [31:0] BNE_A4   = 32'h3280_0004; // bne,a disp=4
  localparam logic [31:0] BA_A8    = 32'h3080_0008; // ba,a  disp=8
  localparam logic [31:0] BNE_NEG8 = 32'h12BF_FFF8; // bne   disp=-8
  localparam logic [31:0] CALL_10  = 32'h4000_0010; // call  disp30=0x10
  localparam logic [31:0] SAVE_I   = 32'h81E0_0000;
  localparam logic [31:0] REST_I   = 32'h81E8_0000;
  localparam logic [31:0] TA_3     = 32'h91D0_2003;
  localparam logic [31:0] TA_7F    = 32'h91D0_207F;

  logic        clk;
  logic        rst_n;
  logic        step;
  logic [31:0] ir;
  logic        cond;
  logic [4:0]  cwp;
  logic [31:0] wim;
  logic        et;
  logic [19:0] tba;
  logic [31:0] pc, npc, trap_pc, trap_npc;
  logic        annul, busy, trap_entry, error_mode;
  logic [7:0]  tt;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_trap_sequencer #(
    .NWIN     (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .step_i       (step),
    .ir_i         (ir),
    .cond_i       (cond),
    .cwp_i        (cwp),
    .wim_i        (wim),
    .et_i         (et),
    .tba_i        (tba),
    .pc_o         (pc),
    .npc_o        (npc),
    .annul_o      (annul),
    .busy_o       (busy),
    .trap_entry_o (trap_entry),
    .tt_o         (tt),
    .trap_pc_o    (trap_pc),
    .trap_npc_o   (trap_npc),
    .error_mode_o (error_mode),
    .state_o      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_step(input logic [31:0] instr, input logic c);
    @(negedge clk);
    step = 1'b1;
    ir   = instr;
    cond = c;
    @(posedge clk);
    #1;
    step = 1'b0;
    ir   = NOP;
    cond = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    step = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pcs(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_npc, input logic e_annul);
    check_eq({tag, ".pc"}, pc, e_pc);
    check_eq({tag, ".npc"}, npc, e_npc);
    check_eq({tag, ".annul"}, {31'b0, annul}, {31'b0, e_annul});
  endtask

  initial begin
    rst_n = 1'b1;
    step  = 1'b0;
    ir    = NOP;
    cond  = 1'b0;
    cwp   = 5'd0;
    wim   = 32'h0;
    et    = 1'b1;
    tba   = 20'h40000;

    apply_reset();
    check_pcs("rst", 32'h0, 32'h4, 1'b0);
    check_eq("rst.busy", {31'b0, busy}, 32'h0);
    check_eq("rst.trap_entry", {31'b0, trap_entry}, 32'h0);
    check_eq("rst.tt", {24'b0, tt}, 32'h0);
    check_eq("rst.trap_pc", trap_pc, 32'h0);
    check_eq("rst.trap_npc", trap_npc, 32'h0);
    check_eq("rst.err", {31'b0, error_mode}, 32'h0);
    check_eq("rst.state", {30'b0, state}, 32'h0);

    do_step(NOP, 1'b0); check_pcs("seq1", 32'h4, 32'h8, 1'b0);
    do_step(NOP, 1'b0); check_pcs("seq2", 32'h8, 32'hC, 1'b0);
    do_step(NOP, 1'b0); check_pcs("seq3", 32'hC, 32'h10, 1'b0);
    idle();             check_pcs("hold", 32'hC, 32'h10, 1'b0);
    do_step(NOP, 1'b0); check_pcs("seq4", 32'h10, 32'h14, 1'b0);

    // bne,a not taken: delay slot annulled; the annulled TA must not trap
    do_step(BNE_A4, 1'b0); check_pcs("bne_nt", 32'h14, 32'h18, 1'b1);
    do_step(TA_3, 1'b1);   check_pcs("annul_slot", 32'h18, 32'h1C, 1'b0);
    check_eq("annul_slot.busy", {31'b0, busy}, 32'h0);

    // bne,a taken from PC=0x10
    apply_reset();
    repeat (4) do_step(NOP, 1'b0);
    check_pcs("to10", 32'h10, 32'h14, 1'b0);
    do_step(BNE_A4, 1'b1); check_pcs("bne_t", 32'h14, 32'h20, 1'b0);
    do_step(NOP, 1'b0);    check_pcs("bne_slot", 32'h20, 32'h24, 1'b0);

    // ba,a taken: slot annulled, target reached afterwards
    do_step(BA_A8, 1'b1);  check_pcs("ba_a", 32'h24, 32'h40, 1'b1);
    do_step(NOP, 1'b0);    check_pcs("ba_slot", 32'h40, 32'h44, 1'b0);

    do_step(CALL_10, 1'b0);  check_pcs("call", 32'h44, 32'h80, 1'b0);
    do_step(NOP, 1'b0);      check_pcs("call_slot", 32'h80, 32'h84, 1'b0);
    do_step(BNE_NEG8, 1'b1); check_pcs("bne_back", 32'h84, 32'h60, 1'b0);

    // SAVE without overflow
    do_step(SAVE_I, 1'b0);   check_pcs("save_ok", 32'h60, 32'h64, 1'b0);

    // SAVE overflow: CWP=0 -> window 3, WIM bit 3 set; step held during busy
    cwp = 5'd0;
    wim = 32'h8;
    do_step(SAVE_I, 1'b0);
    check_eq("sv1.busy", {31'b0, busy}, 32'h1);
    check_eq("sv1.te", {31'b0, trap_entry}, 32'h0);
    check_eq("sv1.tt", {24'b0, tt}, 32'h05);
    check_eq("sv1.trap_pc", trap_pc, 32'h60);
    check_eq("sv1.trap_npc", trap_npc, 32'h64);
    check_eq("sv1.pc", pc, 32'h60);
    do_step(SAVE_I, 1'b0);
    check_eq("sv2.busy", {31'b0, busy}, 32'h1);
    check_eq("sv2.te", {31'b0, trap_entry}, 32'h1);
    check_eq("sv2.pc", pc, 32'h60);
    do_step(SAVE_I, 1'b0);
    check_eq("sv3.busy", {31'b0, busy}, 32'h0);
    check_eq("sv3.te", {31'b0, trap_entry}, 32'h0);
    check_pcs("sv3", 32'h4000_0050, 32'h4000_0054, 1'b0);

    // RESTORE: CWP=3 -> window 0; WIM bit 4 lies above NWIN-1 and is ignored
    cwp = 5'd3;
    wim = 32'h10;
    do_step(REST_I, 1'b0); check_pcs("rest_ok", 32'h4000_0054, 32'h4000_0058, 1'b0);
    wim = 32'h1;
    do_step(REST_I, 1'b0);
    check_eq("rs1.tt", {24'b0, tt}, 32'h06);
    check_eq("rs1.trap_pc", trap_pc, 32'h4000_0054);
    idle();
    idle();
    check_pcs("rs3", 32'h4000_0060, 32'h4000_0064, 1'b0);

    // TA 0x7F with TBA=0xFFFFF: vector 0xFFFFFFF0, then PC wraps
    tba = 20'hFFFFF;
    wim = 32'h0;
    do_step(TA_7F, 1'b0);
    check_eq("ta7f.tt", {24'b0, tt}, 32'hFF);
    idle();
    idle();
    check_pcs("ta7f.vec", 32'hFFFF_FFF0, 32'hFFFF_FFF4, 1'b0);
    do_step(NOP, 1'b0); check_pcs("wrap1", 32'hFFFF_FFF4, 32'hFFFF_FFF8, 1'b0);
    do_step(NOP, 1'b0); check_pcs("wrap2", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0);
    do_step(NOP, 1'b0); check_pcs("wrap3", 32'hFFFF_FFFC, 32'h0, 1'b0);

    // TA with ET=0: error mode, HALT, steps ignored, reset clears
    et = 1'b0;
    do_step(TA_3, 1'b0);
    check_eq("halt.err", {31'b0, error_mode}, 32'h1);
    check_eq("halt.busy", {31'b0, busy}, 32'h1);
    check_eq("halt.state", {30'b0, state}, 32'h3);
    check_pcs("halt", 32'hFFFF_FFFC, 32'h0, 1'b0);
    do_step(NOP, 1'b0);
    do_step(NOP, 1'b0);
    check_pcs("halt_hold", 32'hFFFF_FFFC, 32'h0, 1'b0);
    check_eq("halt_hold.te", {31'b0, trap_entry}, 32'h0);
    apply_reset();
    check_eq("halt_rst.err", {31'b0, error_mode}, 32'h0);
    check_eq("halt_rst.busy", {31'b0, busy}, 32'h0);
    check_pcs("halt_rst", 32'h0, 32'h4, 1'b0);
    et = 1'b1;

    // reset during TRAP_SAVE: no vector, no Trap_Entry
    tba = 20'h40000;
    cwp = 5'd0;
    wim = 32'h8;
    do_step(SAVE_I, 1'b0);
    check_eq("mid.busy", {31'b0, busy}, 32'h1);
    apply_reset();
    check_pcs("mid_rst", 32'h0, 32'h4, 1'b0);
    check_eq("mid_rst.busy", {31'b0, busy}, 32'h0);
    check_eq("mid_rst.te", {31'b0, trap_entry}, 32'h0);
    check_eq("mid_rst.tt", {24'b0, tt}, 32'h0);
    idle();
    check_eq("mid_rst2.te", {31'b0, trap_entry}, 32'h0);
    check_pcs("mid_rst2", 32'h0, 32'h4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
